// File: rtl/addition_tt_pkg.sv
// Shared types and constants for the truth-table addition sweeper and its MISR.
package addition_tt_pkg;

    localparam int DEF_OP_W  = 8;
    localparam int DEF_RES_W = 8;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_EMIT   = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

    typedef struct packed {
        logic [DEF_OP_W-1:0]  op1;
        logic [DEF_OP_W-1:0]  op2;
        logic [DEF_RES_W-1:0] res;
    } tt_rec_t;

endpackage

// File: rtl/tt_misr16.sv
// CRC-16 (poly 0x1021) signature register: absorbs one DATA_W-bit word per enabled
// cycle, MSB first; load_init restarts it from the seed.
module tt_misr16
    import addition_tt_pkg::*;
#(
    parameter int DATA_W = DEF_RES_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_init,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [15:0]       crc
);

    logic [15:0] crc_reg;
    logic [15:0] crc_next;
    logic        feedback;

    // Whole word folded in one clock: the bit-serial LFSR unrolled DATA_W times.
    always_comb begin
        crc_next = crc_reg;
        feedback = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            feedback = crc_next[15] ^ data[i];
            crc_next = {crc_next[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_reg <= CRC16_INIT;
        end else if (load_init) begin
            crc_reg <= CRC16_INIT;
        end else if (en) begin
            crc_reg <= crc_next;
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/addition_tt_sweeper.sv
// Walks every op1/op2 pair in the low RANGE_W bits, samples the circuit result after
// a settle window and streams {op1, op2, result} records. SWEEP_MISR_EN adds a CRC-16 signature.
module addition_tt_sweeper
    import addition_tt_pkg::*;
#(
    parameter int OP_W       = DEF_OP_W,
    parameter int RES_W      = DEF_RES_W,
    parameter int RANGE_W    = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [OP_W-1:0]      op1_o,
    output logic [OP_W-1:0]      op2_o,
    input  logic [RES_W-1:0]     result_i,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [OP_W-1:0]      rec_op1,
    output logic [OP_W-1:0]      rec_op2,
    output logic [RES_W-1:0]     rec_res,
    output logic                 busy,
    output logic                 done,
    output logic [2*RANGE_W:0]   pair_cnt,
    output logic [15:0]          signature
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam int IDX_W = 2 * RANGE_W;
    localparam int PC_W  = 2 * RANGE_W + 1;

    sweep_state_t state_reg, state_next;

    logic [RANGE_W-1:0] op1_lo_reg, op2_lo_reg;
    logic [CNT_W-1:0]   settle_cnt_reg;
    logic [PC_W-1:0]    pair_cnt_reg;
    logic [OP_W-1:0]    rec_op1_reg, rec_op2_reg;
    logic [RES_W-1:0]   rec_res_reg;

    logic               load_start;
    logic               capture;
    logic               accept;
    logic               settle_done;
    logic               last_pair;
    logic [IDX_W-1:0]   pair_idx_inc;

    assign settle_done  = (settle_cnt_reg == CNT_W'(SETTLE_CYC - 1));
    assign last_pair    = (&op1_lo_reg) && (&op2_lo_reg);
    // op2 is the low half, so a single increment gives op1-major order with carry.
    assign pair_idx_inc = {op1_lo_reg, op2_lo_reg} + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // abort overrides every other transition, including a simultaneous start.
    always_comb begin
        state_next = state_reg;
        load_start = 1'b0;
        capture    = 1'b0;
        accept     = 1'b0;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        load_start = 1'b1;
                        state_next = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_done) begin
                        capture    = 1'b1;
                        state_next = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (rec_ready) begin
                        accept     = 1'b1;
                        state_next = last_pair ? ST_DONE : ST_SETTLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_lo_reg     <= '0;
            op2_lo_reg     <= '0;
            settle_cnt_reg <= '0;
            pair_cnt_reg   <= '0;
        end else if (load_start) begin
            op1_lo_reg     <= '0;
            op2_lo_reg     <= '0;
            settle_cnt_reg <= '0;
            pair_cnt_reg   <= '0;
        end else if (accept) begin
            pair_cnt_reg   <= pair_cnt_reg + PC_W'(1);
            settle_cnt_reg <= '0;
            if (!last_pair) begin
                {op1_lo_reg, op2_lo_reg} <= pair_idx_inc;
            end
        end else if (state_reg == ST_SETTLE && !abort) begin
            settle_cnt_reg <= settle_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_op1_reg <= '0;
            rec_op2_reg <= '0;
            rec_res_reg <= '0;
        end else if (capture) begin
            rec_op1_reg <= op1_o;
            rec_op2_reg <= op2_o;
            rec_res_reg <= result_i;
        end
    end

    assign op1_o     = OP_W'(op1_lo_reg);
    assign op2_o     = OP_W'(op2_lo_reg);
    assign rec_op1   = rec_op1_reg;
    assign rec_op2   = rec_op2_reg;
    assign rec_res   = rec_res_reg;
    assign pair_cnt  = pair_cnt_reg;
    assign rec_valid = (state_reg == ST_EMIT);
    assign busy      = (state_reg == ST_SETTLE) || (state_reg == ST_EMIT);
    assign done      = (state_reg == ST_DONE);

`ifdef SWEEP_MISR_EN
    tt_misr16 #(
        .DATA_W (RES_W)
    ) u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_init (load_start),
        .en        (accept),
        .data      (rec_res_reg),
        .crc       (signature)
    );
`else
    assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_addition_tt_sweeper.sv
// Directed bench: DUT "a" (RANGE_W=2, SETTLE_CYC=1) for control behaviour, DUT "b"
// (RANGE_W=4, SETTLE_CYC=2) for an adder loopback. Checks signature with/without SWEEP_MISR_EN.
module tb_addition_tt_sweeper;
    import addition_tt_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic       start_a = 0, abort_a = 0, ready_a = 1;
    logic [7:0] op1_a, op2_a, res_a, rop1_a, rop2_a, rres_a;
    logic       valid_a, busy_a, done_a;
    logic [4:0] pc_a;
    logic [15:0] sig_a;

    logic       start_b = 0, abort_b = 0, ready_b = 1;
    logic [7:0] op1_b, op2_b, res_b, rop1_b, rop2_b, rres_b;
    logic       valid_b, busy_b, done_b;
    logic [8:0] pc_b;
    logic [15:0] sig_b;

    // circuit models: "a" packs operands so the record identifies its pair, "b" adds
    assign res_a = {op1_a[3:0], op2_a[3:0]};
    assign res_b = op1_b + op2_b;

    addition_tt_sweeper #(.OP_W(8), .RES_W(8), .RANGE_W(2), .SETTLE_CYC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .op1_o(op1_a), .op2_o(op2_a), .result_i(res_a),
        .rec_valid(valid_a), .rec_ready(ready_a),
        .rec_op1(rop1_a), .rec_op2(rop2_a), .rec_res(rres_a),
        .busy(busy_a), .done(done_a), .pair_cnt(pc_a), .signature(sig_a)
    );

    addition_tt_sweeper #(.OP_W(8), .RES_W(8), .RANGE_W(4), .SETTLE_CYC(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .op1_o(op1_b), .op2_o(op2_b), .result_i(res_b),
        .rec_valid(valid_b), .rec_ready(ready_b),
        .rec_op1(rop1_b), .rec_op2(rop2_b), .rec_res(rres_b),
        .busy(busy_b), .done(done_b), .pair_cnt(pc_b), .signature(sig_b)
    );

    // reference CRC-CCITT, byte-wise formulation
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    function automatic logic [15:0] exp_sig(input logic [15:0] model);
`ifdef SWEEP_MISR_EN
        return model;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({valid_a, busy_a, done_a} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ctrl got=%b exp=000", {valid_a, busy_a, done_a});
        end
        tests_run++;
        if ({op1_a, op2_a, rop1_a, rop2_a, rres_a, pc_a} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data op1=%0d op2=%0d rop1=%0d rop2=%0d rres=%0d pc=%0d exp all 0",
                     op1_a, op2_a, rop1_a, rop2_a, rres_a, pc_a);
        end
        tests_run++;
        if (sig_a !== exp_sig(16'hFFFF)) begin
            tests_failed++;
            $display("FAIL reset_sig got=%h exp=%h", sig_a, exp_sig(16'hFFFF));
        end
        rst_n = 1'b1;
        tick();
        $display("[TB] reset checked");
    endtask

    task automatic test_full_sweep();
        int idx = 0, cyc = 0, last = -1;
        logic [7:0] e1, e2, er;
        logic [15:0] crc = 16'hFFFF;
        start_a = 1; tick(); start_a = 0;
        tests_run++;
        if ({busy_a, done_a} !== 2'b10) begin
            tests_failed++;
            $display("FAIL sweep_busy got busy=%b done=%b exp busy=1 done=0", busy_a, done_a);
        end
        while (idx < 16 && cyc < 200) begin
            if (valid_a) begin
                e1 = 8'(idx >> 2); e2 = 8'(idx & 3); er = (e1 << 4) | e2;
                tests_run++;
                if ({rop1_a, rop2_a, rres_a} !== {e1, e2, er}) begin
                    tests_failed++;
                    $display("FAIL sweep_rec idx=%0d got=(%0d,%0d,%h) exp=(%0d,%0d,%h)",
                             idx, rop1_a, rop2_a, rres_a, e1, e2, er);
                end
                if (last >= 0) begin
                    tests_run++;
                    if (cyc - last != 2) begin
                        tests_failed++;
                        $display("FAIL sweep_rate idx=%0d got gap=%0d exp=2", idx, cyc - last);
                    end
                end
                if (idx == 15) begin
                    tests_run++;
                    if ({busy_a, done_a} !== 2'b10) begin
                        tests_failed++;
                        $display("FAIL sweep_last_busy got busy=%b done=%b exp 1/0", busy_a, done_a);
                    end
                end
                $display("[TB] sweep rec %0d: (%0d,%0d) res=%h", idx, rop1_a, rop2_a, rres_a);
                crc = crc_ref(crc, er);
                last = cyc;
                idx++;
            end
            tick(); cyc++;
        end
        tests_run++;
        if (idx != 16) begin
            tests_failed++;
            $display("FAIL sweep_count got=%0d exp=16 (timeout)", idx);
        end
        tests_run++;
        if ({busy_a, done_a, valid_a, pc_a} !== {3'b010, 5'd16}) begin
            tests_failed++;
            $display("FAIL sweep_end got busy=%b done=%b valid=%b pc=%0d exp 0/1/0/16",
                     busy_a, done_a, valid_a, pc_a);
        end
        tests_run++;
        if (sig_a !== exp_sig(crc)) begin
            tests_failed++;
            $display("FAIL sweep_sig got=%h exp=%h", sig_a, exp_sig(crc));
        end
    endtask

    task automatic test_backpressure();
        int idx = 0, cyc = 0;
        bit stalled = 0;
        logic [7:0] e1, e2, er, snap;
        logic [15:0] crc = 16'hFFFF;
        start_a = 1; tick(); start_a = 0;   // started from DONE
        tests_run++;
        if ({busy_a, done_a, pc_a} !== {2'b10, 5'd0}) begin
            tests_failed++;
            $display("FAIL restart_from_done got busy=%b done=%b pc=%0d exp 1/0/0", busy_a, done_a, pc_a);
        end
        while (idx < 16 && cyc < 200) begin
            if (valid_a) begin
                e1 = 8'(idx >> 2); e2 = 8'(idx & 3); er = (e1 << 4) | e2;
                if (idx == 6 && !stalled) begin
                    stalled = 1;
                    ready_a = 0;
                    snap = rres_a;
                    for (int k = 0; k < 5; k++) begin
                        tick(); cyc++;
                        tests_run++;
                        if ({valid_a, rop1_a, rop2_a, rres_a, op1_a, op2_a} !==
                            {1'b1, 8'd1, 8'd2, snap, 8'd1, 8'd2}) begin
                            tests_failed++;
                            $display("FAIL stall_hold k=%0d got v=%b rec=(%0d,%0d,%h) op=(%0d,%0d) exp v=1 rec=(1,2,%h) op=(1,2)",
                                     k, valid_a, rop1_a, rop2_a, rres_a, op1_a, op2_a, snap);
                        end
                    end
                    ready_a = 1;
                end
                tests_run++;
                if ({rop1_a, rop2_a, rres_a} !== {e1, e2, er}) begin
                    tests_failed++;
                    $display("FAIL bp_rec idx=%0d got=(%0d,%0d,%h) exp=(%0d,%0d,%h)",
                             idx, rop1_a, rop2_a, rres_a, e1, e2, er);
                end
                $display("[TB] bp rec %0d: (%0d,%0d) res=%h", idx, rop1_a, rop2_a, rres_a);
                crc = crc_ref(crc, er);
                idx++;
            end
            tick(); cyc++;
        end
        tests_run++;
        if ({idx == 16, done_a, pc_a} !== {2'b11, 5'd16}) begin
            tests_failed++;
            $display("FAIL bp_end got idx=%0d done=%b pc=%0d exp 16/1/16", idx, done_a, pc_a);
        end
        tests_run++;
        if (sig_a !== exp_sig(crc)) begin
            tests_failed++;
            $display("FAIL bp_sig got=%h exp=%h", sig_a, exp_sig(crc));
        end
    endtask

    task automatic test_abort();
        int idx = 0, cyc = 0;
        logic [15:0] crc = 16'hFFFF;
        start_a = 1; tick(); start_a = 0;
        while (idx < 7 && cyc < 100) begin
            if (valid_a) begin
                crc = crc_ref(crc, (8'(idx >> 2) << 4) | 8'(idx & 3));
                idx++;
            end
            tick(); cyc++;
        end
        abort_a = 1; tick(); abort_a = 0;
        tests_run++;
        if ({valid_a, busy_a, done_a, pc_a, op1_a, op2_a} !== {3'b000, 5'd7, 8'd1, 8'd3}) begin
            tests_failed++;
            $display("FAIL abort_state got v=%b b=%b d=%b pc=%0d op=(%0d,%0d) exp 0/0/0 pc=7 op=(1,3)",
                     valid_a, busy_a, done_a, pc_a, op1_a, op2_a);
        end
        tests_run++;
        if (sig_a !== exp_sig(crc)) begin
            tests_failed++;
            $display("FAIL abort_sig got=%h exp=%h", sig_a, exp_sig(crc));
        end
        tick();
        tests_run++;
        if ({valid_a, busy_a} !== 2'b00) begin
            tests_failed++;
            $display("FAIL abort_idle got v=%b b=%b exp 0/0", valid_a, busy_a);
        end
        start_a = 1; tick(); start_a = 0;
        tests_run++;
        if ({busy_a, pc_a, op1_a, op2_a} !== {1'b1, 5'd0, 8'd0, 8'd0}) begin
            tests_failed++;
            $display("FAIL abort_restart got b=%b pc=%0d op=(%0d,%0d) exp 1/0/(0,0)", busy_a, pc_a, op1_a, op2_a);
        end
        cyc = 0;
        while (!valid_a && cyc < 20) begin tick(); cyc++; end
        tests_run++;
        if ({valid_a, rop1_a, rop2_a} !== {1'b1, 8'd0, 8'd0}) begin
            tests_failed++;
            $display("FAIL abort_first_rec got v=%b (%0d,%0d) exp 1 (0,0)", valid_a, rop1_a, rop2_a);
        end
        // withdraw a valid record: abort wins over the handshake
        abort_a = 1; tick(); abort_a = 0;
        tests_run++;
        if ({valid_a, pc_a, sig_a} !== {1'b0, 5'd0, exp_sig(16'hFFFF)}) begin
            tests_failed++;
            $display("FAIL abort_withdraw got v=%b pc=%0d sig=%h exp 0/0/%h", valid_a, pc_a, sig_a, exp_sig(16'hFFFF));
        end
        $display("[TB] abort checked");
    endtask

    task automatic test_start_ignored();
        int idx = 0, cyc = 0;
        logic [7:0] e1, e2;
        start_a = 1; tick(); start_a = 0;
        while (idx < 16 && cyc < 200) begin
            if (idx == 5 && !valid_a && busy_a) begin
                start_a = 1; tick(); start_a = 0; cyc++;
                tests_run++;
                if ({busy_a, pc_a} !== {1'b1, 5'd5}) begin
                    tests_failed++;
                    $display("FAIL midstart got b=%b pc=%0d exp 1/5", busy_a, pc_a);
                end
            end
            if (valid_a) begin
                e1 = 8'(idx >> 2); e2 = 8'(idx & 3);
                tests_run++;
                if ({rop1_a, rop2_a} !== {e1, e2}) begin
                    tests_failed++;
                    $display("FAIL midstart_rec idx=%0d got=(%0d,%0d) exp=(%0d,%0d)", idx, rop1_a, rop2_a, e1, e2);
                end
                idx++;
            end
            tick(); cyc++;
        end
        tests_run++;
        if ({done_a, pc_a} !== {1'b1, 5'd16}) begin
            tests_failed++;
            $display("FAIL midstart_end got d=%b pc=%0d exp 1/16", done_a, pc_a);
        end
        abort_a = 1; tick(); abort_a = 0;
        tests_run++;
        if ({done_a, busy_a} !== 2'b00) begin
            tests_failed++;
            $display("FAIL abort_from_done got d=%b b=%b exp 0/0", done_a, busy_a);
        end
        start_a = 1; abort_a = 1; tick(); start_a = 0; abort_a = 0;
        tests_run++;
        if ({busy_a, done_a, valid_a} !== 3'b000) begin
            tests_failed++;
            $display("FAIL start_abort_same got b=%b d=%b v=%b exp 0/0/0", busy_a, done_a, valid_a);
        end
        tick();
        tests_run++;
        if (busy_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_abort_idle got b=%b exp 0", busy_a);
        end
        $display("[TB] start handling checked");
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        start_a = 1; tick(); start_a = 0;
        repeat (4) tick();
        while (!valid_a && cyc < 20) begin tick(); cyc++; end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({valid_a, busy_a, done_a, pc_a, op1_a, op2_a, rop1_a, rop2_a, rres_a} !== '0 ||
            sig_a !== exp_sig(16'hFFFF)) begin
            tests_failed++;
            $display("FAIL async_reset got v=%b b=%b pc=%0d op=(%0d,%0d) rec=(%0d,%0d,%h) sig=%h exp all 0 sig=%h",
                     valid_a, busy_a, pc_a, op1_a, op2_a, rop1_a, rop2_a, rres_a, sig_a, exp_sig(16'hFFFF));
        end
        @(negedge clk); rst_n = 1'b1;
        tick();
        start_a = 1; tick(); start_a = 0;
        cyc = 0;
        while (!valid_a && cyc < 20) begin tick(); cyc++; end
        tests_run++;
        if ({valid_a, rop1_a, rop2_a, pc_a} !== {1'b1, 8'd0, 8'd0, 5'd0}) begin
            tests_failed++;
            $display("FAIL reset_restart got v=%b (%0d,%0d) pc=%0d exp 1 (0,0) 0", valid_a, rop1_a, rop2_a, pc_a);
        end
        abort_a = 1; tick(); abort_a = 0;
        $display("[TB] mid-sweep reset checked");
    endtask

    task automatic test_loopback();
        int idx = 0, cyc = 0, last = -1;
        logic [7:0] e1, e2;
        logic [15:0] crc = 16'hFFFF;
        start_b = 1; tick(); start_b = 0;
        while (idx < 256 && cyc < 2000) begin
            if (valid_b) begin
                e1 = 8'(idx >> 4); e2 = 8'(idx & 15);
                tests_run++;
                if ({rop1_b, rop2_b, rres_b} !== {e1, e2, 8'(e1 + e2)}) begin
                    tests_failed++;
                    $display("FAIL loop_rec idx=%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)",
                             idx, rop1_b, rop2_b, rres_b, e1, e2, 8'(e1 + e2));
                end
                if (last >= 0) begin
                    tests_run++;
                    if (cyc - last != 3) begin
                        tests_failed++;
                        $display("FAIL loop_rate idx=%0d got gap=%0d exp=3", idx, cyc - last);
                    end
                end
                if (idx % 64 == 0) $display("[TB] loopback rec %0d: %0d+%0d=%0d", idx, rop1_b, rop2_b, rres_b);
                crc = crc_ref(crc, 8'(e1 + e2));
                last = cyc;
                idx++;
            end
            tick(); cyc++;
        end
        tests_run++;
        if ({idx == 256, done_b, busy_b, pc_b} !== {3'b110, 9'd256}) begin
            tests_failed++;
            $display("FAIL loop_end got idx=%0d d=%b b=%b pc=%0d exp 256/1/0/256", idx, done_b, busy_b, pc_b);
        end
        tests_run++;
        if (sig_b !== exp_sig(crc)) begin
            tests_failed++;
            $display("FAIL loop_sig got=%h exp=%h", sig_b, exp_sig(crc));
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_backpressure();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/addition_tt_sweeper.md
Name: addition_tt_sweeper

Overview:
Sequential stimulus/response engine that sits on the input side of the team's ABC-generated truth-table addition circuits. It drives the op1/op2 operand buses and walks every operand pair in a configurable low-order range. After a settle window it samples the circuit's result bus and emits one {op1, op2, result} record per pair over a valid/ready stream to a logger. An optional MISR signature compacts all results.

Parameters:
OP_W, 8, operand bus width driven to the circuit
RES_W, 8, result bus width sampled from the circuit
RANGE_W, 4, low operand bits swept (1..OP_W); bits above RANGE_W are driven 0
SETTLE_CYC, 1, cycles operands are held stable before result is sampled (>=1)

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin sweep; honoured only in IDLE or DONE
abort  in  1  synchronous abort from any state
op1_o  out  OP_W  operand 1 to circuit
op2_o  out  OP_W  operand 2 to circuit
result_i  in  RES_W  circuit result
rec_valid  out  1  record valid
rec_ready  in  1  logger accepts record
rec_op1  out  OP_W  operand 1 of record
rec_op2  out  OP_W  operand 2 of record
rec_res  out  RES_W  captured result
busy  out  1  sweep in progress
done  out  1  sweep completed (sticky)
pair_cnt  out  2*RANGE_W+1  records accepted this sweep
signature  out  16  MISR value

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, except signature = 16'hFFFF with SWEEP_MISR_EN defined and 0 without.
- States: IDLE, SETTLE, EMIT, DONE.
- IDLE/DONE + start: op1_o = op2_o = 0, settle counter = 0, pair_cnt = 0, done = 0, signature = FFFF. Next state SETTLE; busy = 1 from the next cycle.
- SETTLE: the settle counter increments each cycle. When it reaches SETTLE_CYC-1:
  - result_i, op1_o and op2_o are registered into the rec_* outputs.
  - rec_valid = 1 from the next cycle; next state EMIT.
- EMIT: all rec_* fields and op*_o are held stable while rec_valid && !rec_ready. On handshake:
  - rec_valid = 0 next cycle; pair_cnt++; MISR updated with rec_res.
  - If op1_o and op2_o both equal 2^RANGE_W-1, go to DONE.
  - Otherwise op2_o++. If op2_o wraps to 0, op1_o++. Return to SETTLE with counter = 0.
- Sweep order is op1-major, op2-minor, giving 2^(2*RANGE_W) records.
- DONE: busy = 0, done = 1 held until the next start. Operands keep their last value.
- With rec_ready constantly high, throughput is one record per SETTLE_CYC+1 cycles.
- abort, any state: next cycle IDLE, busy = 0, rec_valid = 0 (a record may be withdrawn without handshake), done = 0. op*_o, pair_cnt and signature are held.
- start is ignored in SETTLE/EMIT. abort has priority over a simultaneous start.
- Reset mid-sweep returns everything to reset values immediately. No record is completed.
- All operand arithmetic is RANGE_W-bit modulo and zero-extended to OP_W. pair_cnt never wraps (width 2*RANGE_W+1).

Optional Feature:
SWEEP_MISR_EN
- Defined: on each accepted record, signature advances a CRC-16 (poly 0x1021) over rec_res, MSB first, one RES_W-bit step per record. Init FFFF at start.
- Undefined: no MISR logic; signature is tied to 0.

Decomposition:
- Shared package addition_tt_pkg holds:
  - OP_W/RES_W defaults
  - state enum (IDLE, SETTLE, EMIT, DONE)
  - CRC16_POLY = 16'h1021, CRC16_INIT = 16'hFFFF
  - packed record struct {op1, op2, res}
- One sub-module, tt_misr16: parallel-input CRC-16 step with enable, load-init and async active-low reset. It is instantiated only under SWEEP_MISR_EN.

Test Plan:
- RANGE_W=2, SETTLE_CYC=1, rec_ready=1, start: exactly 16 records (0,0),(0,1)…(3,3), one per 2 cycles. done rises after the 16th handshake; pair_cnt=16; busy low in the same cycle done is set.
- Hold rec_ready=0 for 5 cycles at record (1,2): rec_valid stays 1, rec_op1=1, rec_op2=2 and rec_res are stable, op outputs are stable. The next record after release is (1,3); no pair is skipped or duplicated.
- Pulse abort after the 7th handshake: IDLE next cycle, rec_valid=0, busy=0, done=0, pair_cnt=7. A subsequent start restarts at (0,0) with pair_cnt=0.
- Pulse start mid-sweep: no effect. Start in DONE: new sweep with done cleared. Start and abort in the same cycle while IDLE: stays IDLE.
- Deassert rst_n during EMIT: all outputs go to reset values asynchronously; sweep is restartable after release.
- Loopback result_i = op1_o+op2_o (RES_W bits), RANGE_W=4: 256 records each satisfying rec_res = rec_op1+rec_op2. With SWEEP_MISR_EN, signature equals the software CRC model; without it, signature=0.
